// File: rtl/console_pkg.sv
// Shared constants and state encoding for the console text writer.
// Screen geometry, fill code and control characters live here so the display path agrees.
package console_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;

  localparam logic [11:0] ROW_STRIDE   = 12'(COLS);
  localparam logic [11:0] LAST_CELL    = 12'(CELLS - 1);
  localparam logic [11:0] LAST_SCR_DST = 12'(CELLS - COLS - 1);
  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_FILL,
    ST_CLR
  } console_state_t;

  function automatic logic is_printable(input logic [7:0] code);
    return code >= 8'h20;
  endfunction

endpackage

// File: rtl/console_addr_gen.sv
// Row/column to linear text-buffer address (row*80 + col) using shift-add only.
// Also used by the display scan path, so it stays purely combinational.
module console_addr_gen
  import console_pkg::*;
(
  input  logic [4:0]  row,
  input  logic [6:0]  col,
  output logic [11:0] addr
);

  // row*80 == row*64 + row*16; max result 2399 fits comfortably in 12 bits
  assign addr = (12'(row) << 6) + (12'(row) << 4) + 12'(col);

endmodule

// File: rtl/console_text_ctrl.sv
// Terminal-style writer for the 80x30 text buffer: cursor tracking, CR/LF/BS,
// line wrap, scroll-up by row copy through the buffer port, and full-screen clear.
module console_text_ctrl
  import console_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [11:0] text_addr,
  output logic        text_write,
  output logic [7:0]  text_in,
  input  logic [7:0]  text_out
);

  console_state_t state, state_next;

  logic [7:0]  char_q;
  logic [7:0]  cap_q;
  logic [11:0] cnt;

  logic        is_lf, is_cr, is_bs, is_print;
  logic        at_last_col, at_last_row, advance;
  logic [6:0]  put_col;
  logic [11:0] put_addr;

  assign is_lf       = (char_q == CH_LF);
  assign is_cr       = (char_q == CH_CR);
  assign is_bs       = (char_q == CH_BS);
  assign is_print    = is_printable(char_q);
  assign at_last_col = (cursor_x == LAST_COL);
  assign at_last_row = (cursor_y == LAST_ROW);
  assign advance     = (is_print && at_last_col) || is_lf;

  // Backspace erases the cell to the left; everything else targets the cursor cell
  assign put_col = is_bs ? (cursor_x - 7'd1) : cursor_x;

  console_addr_gen u_addr_gen (
    .row  (cursor_y),
    .col  (put_col),
    .addr (put_addr)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    char_ready = 1'b0;
    busy       = 1'b0;
    text_write = 1'b0;
    text_addr  = 12'd0;
    text_in    = 8'h00;
    unique case (state)
      ST_IDLE: begin
        char_ready = !clear_req;
        if (clear_req)       state_next = ST_CLR;
        else if (char_valid) state_next = ST_PUT;
      end
      ST_PUT: begin
        text_addr = put_addr;
        if (is_print) begin
          text_write = 1'b1;
          text_in    = char_q;
        end else if (is_bs && cursor_x != 7'd0) begin
          text_write = 1'b1;
          text_in    = BLANK;
        end
        state_next = (advance && at_last_row) ? ST_SCR_RD : ST_IDLE;
      end
      ST_SCR_RD: begin
        busy       = 1'b1;
        text_addr  = cnt + ROW_STRIDE;
        state_next = ST_SCR_WR;
      end
      ST_SCR_WR: begin
        busy       = 1'b1;
        text_addr  = cnt;
        text_write = 1'b1;
        text_in    = cap_q;
        state_next = (cnt == LAST_SCR_DST) ? ST_SCR_FILL : ST_SCR_RD;
      end
      ST_SCR_FILL: begin
        busy       = 1'b1;
        text_addr  = cnt;
        text_write = 1'b1;
        text_in    = BLANK;
        if (cnt == LAST_CELL) state_next = ST_IDLE;
      end
      ST_CLR: begin
        busy       = 1'b1;
        text_addr  = cnt;
        text_write = 1'b1;
        text_in    = BLANK;
        if (cnt == LAST_CELL) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Cursor, latched character and the shared cell counter. The scroll destination
  // counter runs straight on into the last-row fill, so no reload is needed between them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cursor_x <= 7'd0;
      cursor_y <= 5'd0;
      char_q   <= 8'h00;
      cap_q    <= 8'h00;
      cnt      <= 12'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear_req)       cnt    <= 12'd0;
          else if (char_valid) char_q <= char_data;
        end
        ST_PUT: begin
          cnt <= 12'd0;
          if (is_print && !at_last_col) begin
            cursor_x <= cursor_x + 7'd1;
          end else if (advance) begin
            cursor_x <= 7'd0;
            if (!at_last_row) cursor_y <= cursor_y + 5'd1;
          end else if (is_cr) begin
            cursor_x <= 7'd0;
          end else if (is_bs && cursor_x != 7'd0) begin
            cursor_x <= cursor_x - 7'd1;
          end
        end
        ST_SCR_RD: cap_q <= text_out;
        ST_SCR_WR: cnt <= cnt + 12'd1;
        ST_SCR_FILL: cnt <= cnt + 12'd1;
        ST_CLR: begin
          cnt <= cnt + 12'd1;
          if (cnt == LAST_CELL) begin
            cursor_x <= 7'd0;
            cursor_y <= 5'd0;
          end
        end
        default: cnt <= 12'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_console_text_ctrl.sv
// Bench for console_text_ctrl: table of single characters plus sequences for clear,
// scroll, wrap-at-bottom and reset-during-scroll, with a write scoreboard against a screen model.
module tb_console_text_ctrl;

  logic        clock;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        clear_req;
  logic        busy;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [11:0] text_addr;
  logic        text_write;
  logic [7:0]  text_in;
  logic [7:0]  text_out;

  console_text_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .busy       (busy),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .text_addr  (text_addr),
    .text_write (text_write),
    .text_in    (text_in),
    .text_out   (text_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]  code;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    logic [6:0]  exp_x;
    logic [4:0]  exp_y;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] mem   [0:2399];
  logic [7:0] model [0:2399];
  vec_t       vecs  [20];
  int         total;
  int         bad;
  int         write_count;

  // Display-side buffer: combinational read, registered write
  assign text_out = (text_addr < 12'd2400) ? mem[text_addr] : 8'h00;
  always @(posedge clock) if (text_write && text_addr < 12'd2400) mem[text_addr] <= text_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [11:0] addr, input logic [7:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
    model[addr] = data;
  endtask

  // Row copy up by one, then a blank bottom row, derived from the screen model
  task automatic expectScroll();
    for (int dst = 0; dst < 2320; dst++) expectWrite(12'(dst), model[dst + 80]);
    for (int a = 2320; a < 2400; a++) expectWrite(12'(a), 8'h20);
  endtask

  // Scoreboard: every buffer write must match the oldest expected write
  always @(negedge clock) begin : monitor
    wr_t e;
    if (resetn && text_write) begin
      write_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0h, expected no write", text_addr, text_in);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_addr", 32'(text_addr), 32'(e.addr));
        checkOutput("write_data", 32'(text_in), 32'(e.data));
      end
    end
  end

  // Called at a negedge; returns 1 ns after the accepting edge (the PUT cycle)
  task automatic applyStimulus(input logic [7:0] code);
    int n;
    n = 0;
    while (!char_ready && n < 10000) begin
      @(negedge clock);
      n++;
    end
    if (!char_ready) checkOutput("ready_timeout", 32'(char_ready), 32'd1);
    char_valid = 1'b1;
    char_data  = code;
    @(posedge clock);
    #1 char_valid = 1'b0;
  endtask

  task automatic finishChar();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic sendChar(input logic [7:0] code);
    applyStimulus(code);
    finishChar();
  endtask

  task automatic waitIdle(output int cycles, output int ready_seen);
    cycles     = 0;
    ready_seen = 0;
    while (busy && cycles < 6000) begin
      if (char_ready) ready_seen++;
      cycles++;
      @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cyc;
    int rdy;
    int errs;
    int w0;

    total = 0;
    bad = 0;
    write_count = 0;
    resetn = 1'b0;
    char_valid = 1'b0;
    char_data = 8'h00;
    clear_req = 1'b0;
    for (int i = 0; i < 2400; i++) model[i] = 8'h00;

    vecs[0]  = '{8'h41, 1'b1, 12'd0,   8'h41, 7'd1, 5'd0};
    vecs[1]  = '{8'h42, 1'b1, 12'd1,   8'h42, 7'd2, 5'd0};
    vecs[2]  = '{8'h0D, 1'b0, 12'd0,   8'h00, 7'd0, 5'd0};
    vecs[3]  = '{8'h0A, 1'b0, 12'd0,   8'h00, 7'd0, 5'd1};
    vecs[4]  = '{8'h43, 1'b1, 12'd80,  8'h43, 7'd1, 5'd1};
    vecs[5]  = '{8'h08, 1'b1, 12'd80,  8'h20, 7'd0, 5'd1};
    vecs[6]  = '{8'h08, 1'b0, 12'd0,   8'h00, 7'd0, 5'd1};
    vecs[7]  = '{8'h07, 1'b0, 12'd0,   8'h00, 7'd0, 5'd1};
    vecs[8]  = '{8'h7E, 1'b1, 12'd80,  8'h7E, 7'd1, 5'd1};
    vecs[9]  = '{8'h0A, 1'b0, 12'd0,   8'h00, 7'd0, 5'd2};
    vecs[10] = '{8'h0A, 1'b0, 12'd0,   8'h00, 7'd0, 5'd3};
    vecs[11] = '{8'h31, 1'b1, 12'd240, 8'h31, 7'd1, 5'd3};
    vecs[12] = '{8'h32, 1'b1, 12'd241, 8'h32, 7'd2, 5'd3};
    vecs[13] = '{8'h33, 1'b1, 12'd242, 8'h33, 7'd3, 5'd3};
    vecs[14] = '{8'h34, 1'b1, 12'd243, 8'h34, 7'd4, 5'd3};
    vecs[15] = '{8'hFF, 1'b1, 12'd244, 8'hFF, 7'd5, 5'd3};
    vecs[16] = '{8'h08, 1'b1, 12'd244, 8'h20, 7'd4, 5'd3};
    vecs[17] = '{8'h0D, 1'b0, 12'd0,   8'h00, 7'd0, 5'd3};
    vecs[18] = '{8'h08, 1'b0, 12'd0,   8'h00, 7'd0, 5'd3};
    vecs[19] = '{8'h1B, 1'b0, 12'd0,   8'h00, 7'd0, 5'd3};

    repeat (3) @(negedge clock);
    checkOutput("rst_text_write", 32'(text_write), 32'd0);
    checkOutput("rst_text_addr", 32'(text_addr), 32'd0);
    checkOutput("rst_text_in", 32'(text_in), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("rst_cursor_y", 32'(cursor_y), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("rst_char_ready", 32'(char_ready), 32'd1);

    for (int v = 0; v < 20; v++) begin
      if (vecs[v].exp_wr) expectWrite(vecs[v].exp_addr, vecs[v].exp_data);
      applyStimulus(vecs[v].code);
      checkOutput("vec_put_write", 32'(text_write), 32'(vecs[v].exp_wr));
      checkOutput("vec_put_ready", 32'(char_ready), 32'd0);
      finishChar();
      checkOutput("vec_cursor_x", 32'(cursor_x), 32'(vecs[v].exp_x));
      checkOutput("vec_cursor_y", 32'(cursor_y), 32'(vecs[v].exp_y));
      checkOutput("vec_pending", 32'(exp_q.size()), 32'd0);
    end

    // Clear and a character together: clear wins, character waits
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h5A;
    #1 checkOutput("clr_ready_low", 32'(char_ready), 32'd0);
    for (int a = 0; a < 2400; a++) expectWrite(12'(a), 8'h20);
    @(posedge clock);
    #1 clear_req = 1'b0;
    @(negedge clock);
    waitIdle(cyc, rdy);
    checkOutput("clr_busy_cycles", 32'(cyc), 32'd2400);
    checkOutput("clr_ready_while_busy", 32'(rdy), 32'd0);
    checkOutput("clr_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("clr_cursor_y", 32'(cursor_y), 32'd0);
    checkOutput("clr_pending", 32'(exp_q.size()), 32'd0);
    expectWrite(12'd0, 8'h5A);
    applyStimulus(8'h5A);
    finishChar();
    checkOutput("clr_char_x", 32'(cursor_x), 32'd1);

    // Full row of printables wraps to the next line without extra writes
    sendChar(8'h0D);
    for (int i = 0; i < 80; i++) begin
      expectWrite(12'(i), 8'(8'h61 + (i % 26)));
      sendChar(8'(8'h61 + (i % 26)));
    end
    checkOutput("row_wrap_x", 32'(cursor_x), 32'd0);
    checkOutput("row_wrap_y", 32'(cursor_y), 32'd1);
    checkOutput("row_wrap_pending", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 80; i++) begin
      expectWrite(12'(80 + i), 8'h42);
      sendChar(8'h42);
    end
    for (int i = 0; i < 27; i++) sendChar(8'h0A);
    checkOutput("bottom_y", 32'(cursor_y), 32'd29);

    // LF on the last row scrolls; a held character waits for the scroll to finish
    expectScroll();
    applyStimulus(8'h0A);
    finishChar();
    char_valid = 1'b1;
    char_data  = 8'h51;
    waitIdle(cyc, rdy);
    checkOutput("scr_busy_cycles", 32'(cyc), 32'd4720);
    checkOutput("scr_ready_while_busy", 32'(rdy), 32'd0);
    checkOutput("scr_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("scr_cursor_y", 32'(cursor_y), 32'd29);
    checkOutput("scr_pending", 32'(exp_q.size()), 32'd0);
    errs = 0;
    for (int i = 0; i < 80; i++) if (mem[i] !== 8'h42) errs++;
    checkOutput("scr_row0_not_B", 32'(errs), 32'd0);
    errs = 0;
    for (int i = 2320; i < 2400; i++) if (mem[i] !== 8'h20) errs++;
    checkOutput("scr_row29_not_blank", 32'(errs), 32'd0);
    expectWrite(12'd2320, 8'h51);
    @(posedge clock);
    #1 char_valid = 1'b0;
    checkOutput("held_char_write", 32'(text_write), 32'd1);
    finishChar();
    checkOutput("held_char_x", 32'(cursor_x), 32'd1);

    // Printable at the bottom-right corner is written, then scrolled up into row 28
    sendChar(8'h0D);
    for (int i = 0; i < 79; i++) begin
      expectWrite(12'(2320 + i), 8'h78);
      sendChar(8'h78);
    end
    checkOutput("corner_x", 32'(cursor_x), 32'd79);
    expectWrite(12'd2399, 8'h57);
    expectScroll();
    sendChar(8'h57);
    waitIdle(cyc, rdy);
    checkOutput("wrap_busy_cycles", 32'(cyc), 32'd4720);
    checkOutput("wrap_cell_2319", 32'(mem[2319]), 32'h57);
    checkOutput("wrap_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("wrap_cursor_y", 32'(cursor_y), 32'd29);
    checkOutput("wrap_pending", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a scroll aborts it with no further writes
    expectScroll();
    sendChar(8'h0A);
    repeat (999) @(negedge clock);
    checkOutput("mid_scroll_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("abort_text_write", 32'(text_write), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_text_addr", 32'(text_addr), 32'd0);
    checkOutput("abort_cursor_x", 32'(cursor_x), 32'd0);
    checkOutput("abort_cursor_y", 32'(cursor_y), 32'd0);
    exp_q.delete();
    w0 = write_count;
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
    repeat (200) @(negedge clock);
    checkOutput("abort_writes_after", 32'(write_count - w0), 32'd0);
    checkOutput("abort_char_ready", 32'(char_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
